axil_ctrl_slave: RTL and testbench

AXIL_CTRL_SLAVE -- requirements
Module: axil_ctrl_slave

---
 rtl/axil_ctrl_slave_pkg.sv | 12 +
 rtl/axil_ctrl_slave.sv | 119 +++++++++++
 tb/tb_axil_ctrl_slave.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ctrl_slave_pkg.sv
// axil_ctrl_slave_pkg: shared FSM states, register map constants and response codes
package axil_ctrl_slave_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  localparam int CTRL_OFFSET = 'h00;
  localparam int USER_BASE = 'h10;
  localparam int USER_STRIDE = 4;
  localparam int CTRL_AP_START = 0;
  localparam int CTRL_DONE = 1;
  localparam int CTRL_IDLE = 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axil_ctrl_slave.sv
// axil_ctrl_slave: AXI4-Lite control slave with ap_start/done handshake and user registers
module axil_ctrl_slave
  import axil_ctrl_slave_pkg::*;
#(
  parameter int AXI_ADDR_BITS = 6,
  parameter int AXI_DATA_BITS = 32,
  parameter int AXI_STRB_BITS = AXI_DATA_BITS / 8,
  parameter int NUM_USER_REGS = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   s_axi_control_AWVALID,
  output logic                                   s_axi_control_AWREADY,
  input  logic [AXI_ADDR_BITS-1:0]               s_axi_control_AWADDR,
  input  logic                                   s_axi_control_WVALID,
  output logic                                   s_axi_control_WREADY,
  input  logic [AXI_DATA_BITS-1:0]               s_axi_control_WDATA,
  input  logic [AXI_STRB_BITS-1:0]               s_axi_control_WSTRB,
  output logic                                   s_axi_control_BVALID,
  input  logic                                   s_axi_control_BREADY,
  output logic [1:0]                             s_axi_control_BRESP,
  input  logic                                   s_axi_control_ARVALID,
  output logic                                   s_axi_control_ARREADY,
  input  logic [AXI_ADDR_BITS-1:0]               s_axi_control_ARADDR,
  output logic                                   s_axi_control_RVALID,
  input  logic                                   s_axi_control_RREADY,
  output logic [AXI_DATA_BITS-1:0]               s_axi_control_RDATA,
  output logic [1:0]                             s_axi_control_RRESP,
  output logic                                   ap_start,
  input  logic                                   ap_done,
  input  logic                                   ap_idle,
  output logic [NUM_USER_REGS*AXI_DATA_BITS-1:0] user_regs
);
  localparam int CTRL_WORD = CTRL_OFFSET / USER_STRIDE;
  localparam int USER_WORD = USER_BASE / USER_STRIDE;
  w_state_t                 r_wstate;
  r_state_t                 r_rstate;
  logic [AXI_ADDR_BITS-1:2] r_awaddr;
  logic [AXI_DATA_BITS-1:0] r_user [NUM_USER_REGS];
  logic [AXI_DATA_BITS-1:0] r_rdata;
  logic                     r_ap_start;
  logic                     r_done;
  logic [31:0]              w_widx;
  logic [31:0]              w_ridx;
  logic [AXI_DATA_BITS-1:0] w_rmux;
  logic                     w_unused;
  assign w_widx = 32'(r_awaddr);
  assign w_ridx = 32'(s_axi_control_ARADDR[AXI_ADDR_BITS-1:2]);
  assign w_unused = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};
  assign s_axi_control_AWREADY = (r_wstate == W_IDLE) & ~reset;
  assign s_axi_control_WREADY = (r_wstate == W_DATA) & ~reset;
  assign s_axi_control_BVALID = (r_wstate == W_RESP) & ~reset;
  assign s_axi_control_ARREADY = (r_rstate == R_IDLE) & ~reset;
  assign s_axi_control_RVALID = (r_rstate == R_DATA) & ~reset;
  assign s_axi_control_BRESP = RESP_OKAY;
  assign s_axi_control_RRESP = RESP_OKAY;
  assign s_axi_control_RDATA = r_rdata;
  assign ap_start = r_ap_start;
  for (genvar u = 0; u < NUM_USER_REGS; u++) begin : g_user
    assign user_regs[u*AXI_DATA_BITS +: AXI_DATA_BITS] = r_user[u];
  end
  // Read data mux: register values before any write landing on the same edge
  always_comb begin
    w_rmux = '0;
    if (w_ridx == CTRL_WORD) begin
      w_rmux[CTRL_AP_START] = r_ap_start;
      w_rmux[CTRL_DONE] = r_done;
      w_rmux[CTRL_IDLE] = ap_idle;
    end
    for (int i = 0; i < NUM_USER_REGS; i++)
      if (w_ridx == USER_WORD + i) w_rmux = r_user[i];
  end
  // Write FSM: AW then W then B; applies the write on the W handshake, write beats ap_done
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_ap_start <= 1'b0;
      for (int i = 0; i < NUM_USER_REGS; i++) r_user[i] <= '0;
    end else begin
      if (ap_done) r_ap_start <= 1'b0;
      case (r_wstate)
        W_IDLE: if (s_axi_control_AWVALID) begin
          r_awaddr <= s_axi_control_AWADDR[AXI_ADDR_BITS-1:2];
          r_wstate <= W_DATA;
        end
        W_DATA: if (s_axi_control_WVALID) begin
          r_wstate <= W_RESP;
          if (w_widx == CTRL_WORD && s_axi_control_WSTRB[0])
            r_ap_start <= s_axi_control_WDATA[CTRL_AP_START];
          for (int i = 0; i < NUM_USER_REGS; i++)
            for (int b = 0; b < AXI_STRB_BITS; b++)
              if (w_widx == USER_WORD + i && s_axi_control_WSTRB[b])
                r_user[i][8*b +: 8] <= s_axi_control_WDATA[8*b +: 8];
        end
        W_RESP: if (s_axi_control_BREADY) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
  // Read FSM: capture on AR handshake, hold until R handshake; CTRL read clears done_flag unless ap_done sets it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rdata <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= ap_done | (r_done & ~(s_axi_control_ARVALID & s_axi_control_ARREADY & (w_ridx == CTRL_WORD)));
      case (r_rstate)
        R_IDLE: if (s_axi_control_ARVALID) begin
          r_rdata <= w_rmux;
          r_rstate <= R_DATA;
        end
        R_DATA: if (s_axi_control_RREADY) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_ctrl_slave.sv
// tb_axil_ctrl_slave: directed table-driven bench for axil_ctrl_slave
module tb_axil_ctrl_slave;
  logic         clock = 1'b0;
  logic         reset;
  logic         s_axi_control_AWVALID, s_axi_control_AWREADY;
  logic [5:0]   s_axi_control_AWADDR;
  logic         s_axi_control_WVALID, s_axi_control_WREADY;
  logic [31:0]  s_axi_control_WDATA;
  logic [3:0]   s_axi_control_WSTRB;
  logic         s_axi_control_BVALID, s_axi_control_BREADY;
  logic [1:0]   s_axi_control_BRESP;
  logic         s_axi_control_ARVALID, s_axi_control_ARREADY;
  logic [5:0]   s_axi_control_ARADDR;
  logic         s_axi_control_RVALID, s_axi_control_RREADY;
  logic [31:0]  s_axi_control_RDATA;
  logic [1:0]   s_axi_control_RRESP;
  logic         ap_start, ap_done, ap_idle;
  logic [127:0] user_regs;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [5:0]  raddr;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs [10];

  always #5 clock = ~clock;

  axil_ctrl_slave dut (
    .clock(clock), .reset(reset),
    .s_axi_control_AWVALID(s_axi_control_AWVALID), .s_axi_control_AWREADY(s_axi_control_AWREADY),
    .s_axi_control_AWADDR(s_axi_control_AWADDR),
    .s_axi_control_WVALID(s_axi_control_WVALID), .s_axi_control_WREADY(s_axi_control_WREADY),
    .s_axi_control_WDATA(s_axi_control_WDATA), .s_axi_control_WSTRB(s_axi_control_WSTRB),
    .s_axi_control_BVALID(s_axi_control_BVALID), .s_axi_control_BREADY(s_axi_control_BREADY),
    .s_axi_control_BRESP(s_axi_control_BRESP),
    .s_axi_control_ARVALID(s_axi_control_ARVALID), .s_axi_control_ARREADY(s_axi_control_ARREADY),
    .s_axi_control_ARADDR(s_axi_control_ARADDR),
    .s_axi_control_RVALID(s_axi_control_RVALID), .s_axi_control_RREADY(s_axi_control_RREADY),
    .s_axi_control_RDATA(s_axi_control_RDATA), .s_axi_control_RRESP(s_axi_control_RRESP),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .user_regs(user_regs)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi_control_AWVALID = 1'b1;
    s_axi_control_AWADDR = a;
    @(negedge clock);
    chk1("awready", s_axi_control_AWREADY, 1'b1);
    step();
    s_axi_control_AWVALID = 1'b0;
    s_axi_control_WVALID = 1'b1;
    s_axi_control_WDATA = d;
    s_axi_control_WSTRB = s;
    @(negedge clock);
    chk1("wready", s_axi_control_WREADY, 1'b1);
    step();
    s_axi_control_WVALID = 1'b0;
    @(negedge clock);
    chk1("bvalid", s_axi_control_BVALID, 1'b1);
    chk32("bresp", 32'(s_axi_control_BRESP), 32'h0);
    step();
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    s_axi_control_ARVALID = 1'b1;
    s_axi_control_ARADDR = a;
    @(negedge clock);
    chk1("arready", s_axi_control_ARREADY, 1'b1);
    step();
    s_axi_control_ARVALID = 1'b0;
    @(negedge clock);
    chk1("rvalid", s_axi_control_RVALID, 1'b1);
    chk32("rresp", 32'(s_axi_control_RRESP), 32'h0);
    d = s_axi_control_RDATA;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    vecs[0] = '{6'h10, 32'hDEADBEEF, 4'hF, 6'h10, 32'hDEADBEEF};
    vecs[1] = '{6'h10, 32'h00000011, 4'h1, 6'h10, 32'hDEADBE11};
    vecs[2] = '{6'h14, 32'h12345678, 4'hC, 6'h14, 32'h12340000};
    vecs[3] = '{6'h17, 32'hAABBCCDD, 4'h3, 6'h15, 32'h1234CCDD};
    vecs[4] = '{6'h1C, 32'h0F0F0F0F, 4'hF, 6'h1C, 32'h0F0F0F0F};
    vecs[5] = '{6'h20, 32'h11111111, 4'hF, 6'h20, 32'h00000000};
    vecs[6] = '{6'h3C, 32'h22222222, 4'hF, 6'h3C, 32'h00000000};
    vecs[7] = '{6'h04, 32'h33333333, 4'hF, 6'h04, 32'h00000000};
    vecs[8] = '{6'h00, 32'h00000006, 4'hF, 6'h00, 32'h00000004};
    vecs[9] = '{6'h18, 32'hCAFEF00D, 4'h0, 6'h18, 32'h00000000};
    reset = 1'b1;
    {s_axi_control_AWVALID, s_axi_control_WVALID, s_axi_control_ARVALID} = '0;
    s_axi_control_AWADDR = '0;
    s_axi_control_ARADDR = '0;
    s_axi_control_WDATA = '0;
    s_axi_control_WSTRB = '0;
    s_axi_control_BREADY = 1'b1;
    s_axi_control_RREADY = 1'b1;
    ap_done = 1'b0;
    ap_idle = 1'b1;
    repeat (3) step();
    @(negedge clock);
    chk1("rst_awready", s_axi_control_AWREADY, 1'b0);
    chk1("rst_wready", s_axi_control_WREADY, 1'b0);
    chk1("rst_bvalid", s_axi_control_BVALID, 1'b0);
    chk1("rst_arready", s_axi_control_ARREADY, 1'b0);
    chk1("rst_rvalid", s_axi_control_RVALID, 1'b0);
    chk32("rst_rdata", s_axi_control_RDATA, 32'h0);
    chk1("rst_ap_start", ap_start, 1'b0);
    chk128("rst_user_regs", user_regs, 128'h0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk1("post_rst_awready", s_axi_control_AWREADY, 1'b1);
    chk1("post_rst_arready", s_axi_control_ARREADY, 1'b1);
    step();
    for (int k = 0; k < 10; k++) begin
      axi_write(vecs[k].waddr, vecs[k].wdata, vecs[k].wstrb);
      if (k == 0) chk32("user0_after_write", user_regs[31:0], 32'hDEADBEEF);
      axi_read(vecs[k].raddr, rd);
      chk32($sformatf("vec%0d_rdata", k), rd, vecs[k].rexp);
    end
    chk128("user_regs_table", user_regs, {32'h0F0F0F0F, 32'h0, 32'h1234CCDD, 32'hDEADBE11});
    ap_idle = 1'b0;
    axi_read(6'h00, rd);
    chk32("ctrl_idle_low", rd, 32'h0);
    axi_write(6'h00, 32'h1, 4'h1);
    chk1("ap_start_set", ap_start, 1'b1);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    @(negedge clock);
    chk1("ap_start_cleared", ap_start, 1'b0);
    step();
    axi_read(6'h00, rd);
    chk32("ctrl_done_first", rd, 32'h2);
    axi_read(6'h00, rd);
    chk32("ctrl_done_cleared", rd, 32'h0);
    s_axi_control_AWVALID = 1'b1;
    s_axi_control_AWADDR = 6'h00;
    step();
    s_axi_control_AWVALID = 1'b0;
    s_axi_control_WVALID = 1'b1;
    s_axi_control_WDATA = 32'h1;
    s_axi_control_WSTRB = 4'h1;
    ap_done = 1'b1;
    step();
    s_axi_control_WVALID = 1'b0;
    ap_done = 1'b0;
    @(negedge clock);
    chk1("write_beats_done", ap_start, 1'b1);
    chk1("bvalid_ctrl", s_axi_control_BVALID, 1'b1);
    step();
    axi_read(6'h00, rd);
    chk32("ctrl_start_and_done", rd, 32'h3);
    axi_read(6'h00, rd);
    chk32("ctrl_start_only", rd, 32'h1);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    axi_read(6'h00, rd);
    chk32("ctrl_done_again", rd, 32'h2);
    s_axi_control_ARVALID = 1'b1;
    s_axi_control_ARADDR = 6'h00;
    ap_done = 1'b1;
    step();
    s_axi_control_ARVALID = 1'b0;
    ap_done = 1'b0;
    @(negedge clock);
    chk1("race_rvalid", s_axi_control_RVALID, 1'b1);
    chk32("race_rdata_preclear", s_axi_control_RDATA, 32'h0);
    step();
    axi_read(6'h00, rd);
    chk32("race_done_kept", rd, 32'h2);
    s_axi_control_RREADY = 1'b0;
    s_axi_control_ARVALID = 1'b1;
    s_axi_control_ARADDR = 6'h3C;
    step();
    s_axi_control_ARVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk1($sformatf("hold_rvalid%0d", c), s_axi_control_RVALID, 1'b1);
      chk32($sformatf("hold_rdata%0d", c), s_axi_control_RDATA, 32'h0);
    end
    step();
    s_axi_control_RREADY = 1'b1;
    step();
    @(negedge clock);
    chk1("hold_done_arready", s_axi_control_ARREADY, 1'b1);
    chk1("hold_done_rvalid", s_axi_control_RVALID, 1'b0);
    step();
    s_axi_control_AWVALID = 1'b1;
    s_axi_control_AWADDR = 6'h10;
    step();
    s_axi_control_AWVALID = 1'b0;
    s_axi_control_WVALID = 1'b1;
    s_axi_control_WDATA = 32'h55555555;
    s_axi_control_WSTRB = 4'hF;
    s_axi_control_ARVALID = 1'b1;
    s_axi_control_ARADDR = 6'h10;
    step();
    s_axi_control_WVALID = 1'b0;
    s_axi_control_ARVALID = 1'b0;
    @(negedge clock);
    chk32("same_reg_old_value", s_axi_control_RDATA, 32'hDEADBE11);
    chk32("same_reg_new_value", user_regs[31:0], 32'h55555555);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    s_axi_control_AWVALID = 1'b1;
    s_axi_control_AWADDR = 6'h14;
    step();
    s_axi_control_AWVALID = 1'b0;
    @(negedge clock);
    chk1("abort_in_wdata", s_axi_control_WREADY, 1'b1);
    step();
    reset = 1'b1;
    @(negedge clock);
    chk1("inrst_awready", s_axi_control_AWREADY, 1'b0);
    chk1("inrst_wready", s_axi_control_WREADY, 1'b0);
    chk1("inrst_bvalid", s_axi_control_BVALID, 1'b0);
    chk1("inrst_arready", s_axi_control_ARREADY, 1'b0);
    step();
    @(negedge clock);
    chk32("inrst_rdata", s_axi_control_RDATA, 32'h0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk1("abort_awready", s_axi_control_AWREADY, 1'b1);
    step();
    s_axi_control_WVALID = 1'b1;
    s_axi_control_WDATA = 32'hFFFFFFFF;
    s_axi_control_WSTRB = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk1($sformatf("abort_bvalid%0d", c), s_axi_control_BVALID, 1'b0);
      chk1($sformatf("abort_wready%0d", c), s_axi_control_WREADY, 1'b0);
      step();
    end
    s_axi_control_WVALID = 1'b0;
    @(negedge clock);
    chk32("abort_user1", user_regs[63:32], 32'h0);
    chk128("abort_user_regs", user_regs, 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
